// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (instruction/data) to single memory initiator arbiter; MEM_ARBITER_ROUND_ROBIN_EN selects round-robin, otherwise data has fixed priority.
module mem_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [18:0] instr_m_addr,
  input  logic        instr_m_access,
  output logic        instr_m_ack,
  output logic [15:0] instr_m_data_in,
  input  logic [18:0] data_m_addr,
  input  logic [15:0] data_m_data_out,
  input  logic        data_m_access,
  input  logic        data_m_wr_en,
  input  logic [1:0]  data_m_bytesel,
  output logic        data_m_ack,
  output logic [15:0] data_m_data_in,
  output logic [18:0] q_m_addr,
  output logic [15:0] q_m_data_out,
  output logic        q_m_access,
  output logic        q_m_wr_en,
  output logic [1:0]  q_m_bytesel,
  input  logic        q_m_ack,
  input  logic [15:0] q_m_data_in
);
  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;
  state_t state;
  logic req, pick_d, gi, gd;
  assign req = instr_m_access | data_m_access;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  logic last_grant;
  // last_grant: 1 = data was granted most recently
  assign pick_d = data_m_access & (~instr_m_access | ~last_grant);
  always_ff @(posedge clk or negedge reset)
    if (!reset) last_grant <= 1'b0;
    else if (state == IDLE && req) last_grant <= pick_d;
`else
  assign pick_d = data_m_access;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else if (state == IDLE) state <= req ? (pick_d ? GRANT_D : GRANT_I) : IDLE;
    else if (q_m_ack) state <= IDLE;
  assign gi = state == GRANT_I;
  assign gd = state == GRANT_D;
  assign q_m_access   = gi | gd;
  assign q_m_addr     = gd ? data_m_addr : gi ? instr_m_addr : '0;
  assign q_m_data_out = q_m_access ? data_m_data_out : '0;
  assign q_m_wr_en    = gd & data_m_wr_en;
  assign q_m_bytesel  = gd ? data_m_bytesel : gi ? 2'b11 : 2'b00;
  assign instr_m_ack  = gi & q_m_ack;
  assign data_m_ack   = gd & q_m_ack;
  assign instr_m_data_in = q_m_data_in;
  assign data_m_data_in  = q_m_data_in;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven cycle vectors plus hand sequences for arbitration and reset corners of mem_arbiter.
module tb_mem_arbiter;
  logic clk = 0, reset = 0;
  logic [18:0] instr_m_addr = 0, data_m_addr = 0, q_m_addr;
  logic instr_m_access = 0, data_m_access = 0, data_m_wr_en = 0, q_m_ack = 0;
  logic [1:0] data_m_bytesel = 0, q_m_bytesel;
  logic [15:0] data_m_data_out = 0, q_m_data_in = 0, instr_m_data_in, data_m_data_in, q_m_data_out;
  logic instr_m_ack, data_m_ack, q_m_access, q_m_wr_en;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  mem_arbiter dut (.clk(clk), .reset(reset), .instr_m_addr(instr_m_addr), .instr_m_access(instr_m_access),
    .instr_m_ack(instr_m_ack), .instr_m_data_in(instr_m_data_in), .data_m_addr(data_m_addr),
    .data_m_data_out(data_m_data_out), .data_m_access(data_m_access), .data_m_wr_en(data_m_wr_en),
    .data_m_bytesel(data_m_bytesel), .data_m_ack(data_m_ack), .data_m_data_in(data_m_data_in),
    .q_m_addr(q_m_addr), .q_m_data_out(q_m_data_out), .q_m_access(q_m_access), .q_m_wr_en(q_m_wr_en),
    .q_m_bytesel(q_m_bytesel), .q_m_ack(q_m_ack), .q_m_data_in(q_m_data_in));
  typedef struct {
    logic ia; logic [18:0] iaddr;
    logic da; logic [18:0] daddr; logic dwe; logic [1:0] dbs; logic [15:0] ddo;
    logic qack; logic [15:0] qdi;
    logic eacc; logic [18:0] eaddr; logic ewe; logic [1:0] ebs; logic [15:0] edo; logic eiack; logic edack;
  } vec_t;
  vec_t vecs[$];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chk_idle(input string name);
    chk(name, {q_m_access, q_m_addr, q_m_wr_en, q_m_bytesel, q_m_data_out, instr_m_ack, data_m_ack}, 64'h0);
  endtask
  logic [18:0] exp_addr;
  initial begin
    //          ia iaddr     da daddr     we bs     ddo        qa qdi       acc addr      we bs     do         ia da
    vecs.push_back('{1, 19'h00100, 0, 19'h0, 0, 2'b00, 16'h1234, 0, 16'h0000, 0, 19'h0,     0, 2'b00, 16'h0000, 0, 0});
    vecs.push_back('{1, 19'h00100, 0, 19'h0, 0, 2'b00, 16'h1234, 0, 16'h0000, 1, 19'h00100, 0, 2'b11, 16'h1234, 0, 0});
    vecs.push_back('{1, 19'h00100, 0, 19'h0, 0, 2'b00, 16'h1234, 0, 16'h0000, 1, 19'h00100, 0, 2'b11, 16'h1234, 0, 0});
    vecs.push_back('{1, 19'h00100, 0, 19'h0, 0, 2'b00, 16'h1234, 1, 16'hBEEF, 1, 19'h00100, 0, 2'b11, 16'h1234, 1, 0});
    vecs.push_back('{0, 19'h00100, 0, 19'h0, 0, 2'b00, 16'h1234, 0, 16'h0000, 0, 19'h0,     0, 2'b00, 16'h0000, 0, 0});
    vecs.push_back('{0, 19'h0, 1, 19'h12345, 1, 2'b01, 16'h00AA, 0, 16'h0000, 0, 19'h0,     0, 2'b00, 16'h0000, 0, 0});
    vecs.push_back('{0, 19'h0, 1, 19'h12345, 1, 2'b01, 16'h00AA, 1, 16'hCAFE, 1, 19'h12345, 1, 2'b01, 16'h00AA, 0, 1});
    vecs.push_back('{0, 19'h0, 0, 19'h12345, 1, 2'b01, 16'h00AA, 0, 16'h0000, 0, 19'h0,     0, 2'b00, 16'h0000, 0, 0});
    vecs.push_back('{0, 19'h0, 0, 19'h0, 0, 2'b00, 16'h0000, 1, 16'h7777, 0, 19'h0,         0, 2'b00, 16'h0000, 0, 0});
    vecs.push_back('{0, 19'h0, 0, 19'h0, 0, 2'b00, 16'h0000, 0, 16'h0000, 0, 19'h0,         0, 2'b00, 16'h0000, 0, 0});
    vecs.push_back('{0, 19'h0, 1, 19'h00001, 1, 2'b10, 16'h55AA, 0, 16'h0000, 0, 19'h0,     0, 2'b00, 16'h0000, 0, 0});
    vecs.push_back('{0, 19'h0, 0, 19'h00001, 1, 2'b10, 16'h55AA, 0, 16'h0000, 1, 19'h00001, 1, 2'b10, 16'h55AA, 0, 0});
    vecs.push_back('{0, 19'h0, 0, 19'h00001, 1, 2'b10, 16'h55AA, 1, 16'h1111, 1, 19'h00001, 1, 2'b10, 16'h55AA, 0, 1});
    vecs.push_back('{0, 19'h0, 0, 19'h00001, 1, 2'b10, 16'h55AA, 0, 16'h0000, 0, 19'h0,     0, 2'b00, 16'h0000, 0, 0});
    #1 chk_idle("reset_state");
    @(negedge clk) reset = 1;
    foreach (vecs[i]) begin
      @(negedge clk);
      {instr_m_access, instr_m_addr, data_m_access, data_m_addr} = {vecs[i].ia, vecs[i].iaddr, vecs[i].da, vecs[i].daddr};
      {data_m_wr_en, data_m_bytesel, data_m_data_out, q_m_ack, q_m_data_in} = {vecs[i].dwe, vecs[i].dbs, vecs[i].ddo, vecs[i].qack, vecs[i].qdi};
      #1;
      chk($sformatf("vec%0d_outs", i),
        {q_m_access, q_m_addr, q_m_wr_en, q_m_bytesel, q_m_data_out, instr_m_ack, data_m_ack},
        {vecs[i].eacc, vecs[i].eaddr, vecs[i].ewe, vecs[i].ebs, vecs[i].edo, vecs[i].eiack, vecs[i].edack});
      chk($sformatf("vec%0d_rdata", i), {instr_m_data_in, data_m_data_in}, {vecs[i].qdi, vecs[i].qdi});
    end
    // simultaneous requests held continuously, starting from reset
    @(negedge clk);
    q_m_ack = 0; reset = 0;
    instr_m_access = 1; instr_m_addr = 19'h00111;
    data_m_access = 1; data_m_addr = 19'h00222; data_m_wr_en = 0; data_m_bytesel = 2'b11; data_m_data_out = 16'h0;
    @(negedge clk) reset = 1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      exp_addr = (k % 2 == 0) ? 19'h00222 : 19'h00111;
`else
      exp_addr = 19'h00222;
`endif
      q_m_ack = 1;
      #1;
      chk($sformatf("sim%0d_grant", k), {q_m_access, q_m_addr}, {1'b1, exp_addr});
      chk($sformatf("sim%0d_acks", k), {instr_m_ack, data_m_ack}, {exp_addr == 19'h00111, exp_addr == 19'h00222});
      @(negedge clk) q_m_ack = 0;
      #1 chk_idle($sformatf("sim%0d_idle", k));
    end
    data_m_access = 0;
    @(negedge clk);
    q_m_ack = 1;
    #1 chk("sim_instr_after_drop", {q_m_access, q_m_addr, instr_m_ack, data_m_ack}, {1'b1, 19'h00111, 1'b1, 1'b0});
    @(negedge clk) begin q_m_ack = 0; instr_m_access = 0; end
    // reset while in GRANT_D, then re-arbitration of the held request
    data_m_access = 1; data_m_addr = 19'h00333; data_m_wr_en = 1; data_m_bytesel = 2'b11;
    @(negedge clk);
    #1 chk("rst_pre_grant", {q_m_access, q_m_addr}, {1'b1, 19'h00333});
    q_m_ack = 1; reset = 0;
    #1 chk("rst_async", {q_m_access, instr_m_ack, data_m_ack}, 3'b000);
    chk_idle("rst_async_idle");
    @(negedge clk) begin reset = 1; q_m_ack = 0; end
    #1 chk("rst_released_idle", {q_m_access}, 1'b0);
    @(negedge clk);
    #1 chk("rst_rearb", {q_m_access, q_m_addr, q_m_wr_en}, {1'b1, 19'h00333, 1'b1});
    q_m_ack = 1;
    #1 chk("rst_rearb_ack", {instr_m_ack, data_m_ack}, 2'b01);
    @(negedge clk) begin q_m_ack = 0; data_m_access = 0; end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port bus responder that terminates the core's instruction-fetch bus and data bus and multiplexes them onto a single downstream memory initiator port. It sits between the CPU core and the memory/peripheral fabric. It grants one transaction at a time, forwards address, write data and control to memory, and routes the memory acknowledge back to the granted port only. Read data is broadcast to both ports.

## Interface
Parameters: none.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- instr_m_addr  in  19  instruction word address [19:1].
- instr_m_access  in  1  instruction read request.
- instr_m_ack  out  1  instruction transfer complete (1-cycle pulse).
- instr_m_data_in  out  16  instruction read data.
- data_m_addr  in  19  data word address [19:1].
- data_m_data_out  in  16  write data from core.
- data_m_access  in  1  data request.
- data_m_wr_en  in  1  1 = write, 0 = read.
- data_m_bytesel  in  2  byte lanes ([0] low byte, [1] high byte).
- data_m_ack  out  1  data transfer complete (1-cycle pulse).
- data_m_data_in  out  16  data read data.
- q_m_addr  out  19  downstream word address.
- q_m_data_out  out  16  downstream write data.
- q_m_access  out  1  downstream request.
- q_m_wr_en  out  1  downstream write enable.
- q_m_bytesel  out  2  downstream byte lanes.
- q_m_ack  in  1  downstream completion.
- q_m_data_in  in  16  downstream read data.

## Operation
- Protocol on all ports: the initiator raises access with addr, wr_en, bytesel and write data stable, and holds them until ack. Ack is high for exactly one cycle. The initiator may present a new request in the cycle after ack.
- State machine:
  - IDLE: if no request is pending, stay in IDLE. Otherwise go to GRANT_D or GRANT_I, chosen by the arbitration policy (see Configuration).
  - GRANT_I: forward instr_m_addr on q_m_addr. Drive q_m_wr_en=0 and q_m_bytesel=2'b11. q_m_data_out is don't-care and is driven with data_m_data_out.
  - GRANT_D: forward data_m_addr, data_m_data_out, data_m_wr_en and data_m_bytesel.
  - In either grant state: q_m_access=1. When q_m_ack=1, pass it combinationally to the granted port's ack and go to IDLE.
- The non-granted port's ack is always 0.
- instr_m_data_in and data_m_data_in both equal q_m_data_in at all times, combinationally.
- A grant is held until q_m_ack arrives, even if the granted port's access drops. Dropping access early is a protocol violation. The transaction still completes downstream, and the stray ack is still forwarded.
- q_m_ack received in IDLE is ignored and produces no upstream ack.

## Timing
- Reset (asynchronous): state=IDLE, q_m_access=0, instr_m_ack=0, data_m_ack=0. Because the data outputs are combinational, q_m_addr, q_m_data_out, q_m_wr_en and q_m_bytesel are 0 while in IDLE. Any in-flight downstream transaction is abandoned.
- Grant latency: a request sampled in IDLE at edge N gives q_m_access=1 from edge N through the cycle in which q_m_ack=1.
- With zero-wait memory (q_m_ack high in the first grant cycle), upstream ack appears 1 cycle after the request is sampled.
- After every completion there is exactly one IDLE cycle. Peak throughput is one transfer per 2 cycles.
- Downstream outputs change only on state transitions. They are stable for the whole grant.
- Both ports requesting in the same IDLE cycle is resolved by the policy. The loser keeps its request held and is granted at the next IDLE.

## Configuration
- Macro: MEM_ARBITER_ROUND_ROBIN_EN.
- When defined:
  - A 1-bit last_grant register (reset value: instruction) records the most recent grant.
  - On a simultaneous request, the port that was not granted last wins.
  - A single request is always granted immediately.
- When undefined:
  - Fixed priority: data wins over instruction.
  - No last_grant register is present.

## Test plan
- Single instruction read:
  - Stimulus: instr_m_addr=19'h00100, access=1; memory acks after 2 wait cycles with data 16'hBEEF.
  - Required: q_m_wr_en=0, q_m_bytesel=11, instr_m_ack pulses once with instr_m_data_in=BEEF, data_m_ack stays 0.
- Data byte write:
  - Stimulus: data addr 19'h12345, wr_en=1, bytesel=01, data_out=16'h00AA; zero-wait memory.
  - Required: q_m_* mirrors these values, data_m_ack is high 1 cycle after the request, then one IDLE cycle follows.
- Simultaneous requests, macro undefined:
  - Stimulus: both ports request continuously.
  - Required: the data port is granted first; instruction is granted only after the data request drops.
- Simultaneous requests, MEM_ARBITER_ROUND_ROBIN_EN defined:
  - Stimulus: both ports request continuously for 6 transfers.
  - Required: grants alternate D,I,D,I,D,I (the first grant is D because last_grant resets to instruction).
- Reset mid-transfer:
  - Stimulus: assert reset while in GRANT_D, before q_m_ack.
  - Required: q_m_access=0 and both acks=0 immediately, without waiting for a clock edge. After release, a held request is re-arbitrated from IDLE.
- Spurious ack:
  - Stimulus: q_m_ack=1 while in IDLE.
  - Required: no upstream ack and no state change.
